// File: rtl/bta_stream_sum8.sv
// rtl/bta_stream_sum8.sv - serial-in front end for the 8-operand binary-tree adder
// Collects eight words over valid/ready, reduces them in three registered levels, holds the sum.
module bta_stream_sum8 #(
  parameter int M = 16,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_data,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M+2:0] out_sum
);

  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {
    COLLECT,
    L1,
    L2,
    L3,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [M-1:0]    op_q [N];
  logic            cin_q;
  logic [M:0]      s1_q [4];
  logic [M+1:0]    s2_q [2];
  logic [M+2:0]    sum_q;
  logic            accept;

  assign accept = (state_q == COLLECT) && in_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      COLLECT: begin
        if (in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) state_d = L1;
        end
      end
      L1:      state_d = L2;
      L2:      state_d = L3;
      L3:      state_d = HOLD;
      HOLD:    if (out_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand buffer and adder tree; every addition zero-extends by one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) op_q[i] <= '0;
      for (int i = 0; i < 4; i++) s1_q[i] <= '0;
      s2_q[0] <= '0;
      s2_q[1] <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      if (accept) begin
        op_q[cnt_q] <= in_data;
        if (cnt_q == '0) cin_q <= in_cin;
      end
      if (state_q == L1) begin
        for (int i = 0; i < 4; i++) begin
          s1_q[i] <= {1'b0, op_q[2*i]} + {1'b0, op_q[2*i+1]};
        end
      end
      if (state_q == L2) begin
        s2_q[0] <= {1'b0, s1_q[0]} + {1'b0, s1_q[1]};
        s2_q[1] <= {1'b0, s1_q[2]} + {1'b0, s1_q[3]};
      end
      if (state_q == L3) begin
        sum_q <= {1'b0, s2_q[0]} + {1'b0, s2_q[1]} + {{(M+2){1'b0}}, cin_q};
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == COLLECT);
    out_valid = (state_q == HOLD);
    out_sum   = sum_q;
  end

endmodule
